// File: rtl/isa_pkg.sv
// Shared ISA constants for the fetch slice: LM/SM opcodes, bubble word, PC width,
// sequencer state type and the "more than one mask bit set" test.
package isa_pkg;

    localparam int          PC_W        = 16;
    localparam logic [3:0]  OP_LM       = 4'b0110;
    localparam logic [3:0]  OP_SM       = 4'b0111;
    localparam logic [15:0] NOP_IR_WORD = 16'hF000;

    typedef enum logic {
        ST_IDLE,
        ST_SEQ
    } seq_state_t;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic multi_bit(input logic [7:0] m);
        return (m & (m - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode/hazard/imem signal bundle. master = fetch stage, slave = its surroundings.
interface fetch_if;
    import isa_pkg::*;

    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic            stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] fromPipe1PC;
    logic [15:0]     IR;
    logic            pipe1_valid;
    logic [2:0]      lmsm_idx;
    logic            lmsm_busy;

    modport master (
        output imem_addr, fromPipe1PC, IR, pipe1_valid, lmsm_idx, lmsm_busy,
        input  imem_data, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_addr, fromPipe1PC, IR, pipe1_valid, lmsm_idx, lmsm_busy,
        output imem_data, stall, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_stage_lmsm_seq.sv
// LM/SM micro-sequencer: decides when a loaded LM/SM needs extra pipe1 copies and counts them.
//  state   | meaning
//  ST_IDLE | normal fetch; a multi-bit LM/SM load enters ST_SEQ
//  ST_SEQ  | issuing further copies, PC frozen, lmsm_busy=1
module lmsm_seq
    import isa_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       abort,
    input  logic       hold,
    input  logic [3:0] load_op,
    input  logic [7:0] load_mask,
    input  logic [7:0] cur_mask,
    output logic       busy,
    output logic [2:0] idx,
    output logic [7:0] next_mask
);

    seq_state_t state, state_nxt;
    logic [2:0] idx_nxt;

    assign next_mask = cur_mask & (cur_mask - 8'd1);
    assign busy      = (state == ST_SEQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= 3'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (abort) begin
            state_nxt = ST_IDLE;
            idx_nxt   = 3'd0;
        end else if (!hold) begin
            case (state)
                ST_IDLE: begin
                    idx_nxt = 3'd0;
                    if ((load_op == OP_LM || load_op == OP_SM) && multi_bit(load_mask))
                        state_nxt = ST_SEQ;
                end
                ST_SEQ: begin
                    idx_nxt = idx + 3'd1;
                    // Last copy is the one left with a single mask bit.
                    if (!multi_bit(next_mask))
                        state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage + pipe1 register: PC, imem read, stall/redirect and LM/SM copy issue.
// Optional FETCH_STATS_EN adds saturating stat_fetch / stat_stall counters.
module fetch_stage
    import isa_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [15:0]     NOP_IR   = NOP_IR_WORD
) (
    input  logic       clk,
    input  logic       reset,
`ifdef FETCH_STATS_EN
    output logic [15:0] stat_fetch,
    output logic [15:0] stat_stall,
`endif
    fetch_if.master    bus
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pipe_pc;
    logic [15:0]     ir;
    logic            valid;
    logic            busy;
    logic [2:0]      idx;
    logic [7:0]      next_mask;
    logic            load;
    logic            seq_step;

    assign load     = !bus.redirect && !bus.stall && !busy;
    assign seq_step = !bus.redirect && !bus.stall && busy;

    lmsm_seq u_seq (
        .clk       (clk),
        .reset     (reset),
        .abort     (bus.redirect),
        .hold      (bus.stall),
        .load_op   (bus.imem_data[15:12]),
        .load_mask (bus.imem_data[7:0]),
        .cur_mask  (ir[7:0]),
        .busy      (busy),
        .idx       (idx),
        .next_mask (next_mask)
    );

    // PC already points past the LM/SM once it is loaded, so copies leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= NOP_IR;
            pipe_pc <= '0;
            valid   <= 1'b0;
        end else if (bus.redirect) begin
            pc    <= bus.redirect_pc;
            ir    <= NOP_IR;
            valid <= 1'b0;
        end else if (load) begin
            pc      <= pc + 16'd1;
            ir      <= bus.imem_data;
            pipe_pc <= pc;
            valid   <= 1'b1;
        end else if (seq_step) begin
            ir[7:0] <= next_mask;
            valid   <= 1'b1;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.IR          = ir;
    assign bus.fromPipe1PC = pipe_pc;
    assign bus.pipe1_valid = valid;
    assign bus.lmsm_idx    = idx;
    assign bus.lmsm_busy   = busy;

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fetch <= 16'd0;
            stat_stall <= 16'd0;
        end else begin
            if (load && stat_fetch != 16'hFFFF)
                stat_fetch <= stat_fetch + 16'd1;
            if (bus.stall && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed LM/SM, stall, redirect and wrap cases, then random
// stall/redirect traffic checked against a queue-based model of issued copies.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] mem [256];

    fetch_if bus();

`ifdef FETCH_STATS_EN
    logic [15:0] stat_fetch, stat_stall;
`endif

    fetch_stage #(.RESET_PC(16'h0000), .NOP_IR(16'hF000)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef FETCH_STATS_EN
        .stat_fetch (stat_fetch),
        .stat_stall (stat_stall),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = mem[bus.imem_addr[7:0]];

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc, m_ppc, m_ir;
    logic        m_valid;
    logic [2:0]  m_idx;
    logic [15:0] pend [$];
    int          m_fetch, m_stall;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_ppc = 16'h0000; m_ir = 16'hF000;
        m_valid = 1'b0; m_idx = 3'd0; pend.delete();
        m_fetch = 0; m_stall = 0;
    endtask

    // Copies of an LM/SM: each one drops the lowest remaining mask bit until one bit is left.
    task automatic expand(input logic [15:0] w);
        logic [7:0] m;
        m = w[7:0];
        if (w[15:12] == 4'b0110 || w[15:12] == 4'b0111) begin
            while ($countones(m) > 1) begin
                for (int k = 0; k < 8; k++) begin
                    if (m[k]) begin
                        m[k] = 1'b0;
                        break;
                    end
                end
                pend.push_back({w[15:8], m});
            end
        end
    endtask

    task automatic model_edge(input logic st, input logic rd, input logic [15:0] rpc);
        logic [15:0] w;
        if (st && m_stall < 65535) m_stall++;
        if (rd) begin
            m_pc = rpc; m_ir = 16'hF000; m_valid = 1'b0; m_idx = 3'd0; pend.delete();
        end else if (!st) begin
            if (pend.size() != 0) begin
                m_ir = pend.pop_front();
                m_idx = m_idx + 3'd1;
                m_valid = 1'b1;
            end else begin
                w = mem[m_pc[7:0]];
                m_ppc = m_pc;
                m_pc = m_pc + 16'd1;
                m_ir = w;
                m_valid = 1'b1;
                m_idx = 3'd0;
                if (m_fetch < 65535) m_fetch++;
                expand(w);
            end
        end
    endtask

    task automatic compare_all();
        check_eq("imem_addr", {16'h0, bus.imem_addr}, {16'h0, m_pc});
        check_eq("IR", {16'h0, bus.IR}, {16'h0, m_ir});
        check_eq("pipe1_valid", {31'h0, bus.pipe1_valid}, {31'h0, m_valid});
        check_eq("lmsm_busy", {31'h0, bus.lmsm_busy}, {31'h0, (pend.size() != 0)});
        check_eq("lmsm_idx", {29'h0, bus.lmsm_idx}, {29'h0, m_idx});
        if (m_valid)
            check_eq("fromPipe1PC", {16'h0, bus.fromPipe1PC}, {16'h0, m_ppc});
    endtask

    task automatic step(input logic st, input logic rd, input logic [15:0] rpc);
        bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc;
        @(posedge clk);
        #1;
        model_edge(st, rd, rpc);
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 16'h0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_IR", {16'h0, bus.IR}, 32'h0000F000);
        check_eq("reset_pc", {16'h0, bus.imem_addr}, 32'h0);
        check_eq("reset_ppc", {16'h0, bus.fromPipe1PC}, 32'h0);
        check_eq("reset_valid", {31'h0, bus.pipe1_valid}, 32'h0);
        reset = 1'b0;
        repeat (5) step(1'b0, 1'b0, 16'h0);

        // Reset mid-run, word 1234 at PC 0.
        mem[0] = 16'h1234;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("midrst_IR", {16'h0, bus.IR}, 32'h0000F000);
        check_eq("midrst_valid", {31'h0, bus.pipe1_valid}, 32'h0);
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
        step(1'b0, 1'b0, 16'h0);
        check_eq("t1_IR", {16'h0, bus.IR}, 32'h00001234);
        check_eq("t1_ppc", {16'h0, bus.fromPipe1PC}, 32'h0);

        // LM 60A5 with a 2-cycle stall on copy 2, then completion.
        mem[8'h10] = 16'h60A5;
        mem[8'h11] = 16'h1111;
        step(1'b0, 1'b1, 16'h0010);
        step(1'b0, 1'b0, 16'h0);
        check_eq("t2_c0", {16'h0, bus.IR}, 32'h000060A5);
        step(1'b0, 1'b0, 16'h0);
        check_eq("t2_c1", {16'h0, bus.IR}, 32'h000060A4);
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        check_eq("t3_hold_IR", {16'h0, bus.IR}, 32'h000060A4);
        check_eq("t3_hold_pc", {16'h0, bus.imem_addr}, 32'h00000011);
        step(1'b0, 1'b0, 16'h0);
        check_eq("t2_c2", {16'h0, bus.IR}, 32'h000060A0);
        step(1'b0, 1'b0, 16'h0);
        check_eq("t2_c3", {16'h0, bus.IR}, 32'h00006080);
        check_eq("t2_idx3", {29'h0, bus.lmsm_idx}, 32'd3);
        check_eq("t2_pc_frozen", {16'h0, bus.imem_addr}, 32'h00000011);
        step(1'b0, 1'b0, 16'h0);
        check_eq("t2_resume", {16'h0, bus.IR}, 32'h00001111);

        // Redirect together with stall in the middle of a sequence.
        step(1'b0, 1'b1, 16'h0010);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h0040);
        check_eq("t4_pc", {16'h0, bus.imem_addr}, 32'h00000040);
        check_eq("t4_IR", {16'h0, bus.IR}, 32'h0000F000);
        check_eq("t4_busy", {31'h0, bus.lmsm_busy}, 32'h0);
        check_eq("t4_idx", {29'h0, bus.lmsm_idx}, 32'h0);

        // PC wrap and SM with an empty mask.
        mem[8'hFF] = 16'h1111;
        mem[0]     = 16'h7000;
        step(1'b0, 1'b1, 16'hFFFF);
        step(1'b0, 1'b0, 16'h0);
        check_eq("t5_wrap", {16'h0, bus.imem_addr}, 32'h0);
        step(1'b0, 1'b0, 16'h0);
        check_eq("t5_sm00_busy", {31'h0, bus.lmsm_busy}, 32'h0);
        step(1'b0, 1'b0, 16'h0);

        // Random traffic with plenty of LM/SM words including full and empty masks.
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 3))
                0: mem[i] = {3'b011, 1'($urandom), 4'($urandom), 8'($urandom)};
                1: mem[i] = {3'b011, 1'($urandom), 4'($urandom), 8'hFF};
                default: mem[i] = 16'($urandom);
            endcase
        end
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, 16'($urandom));
        end

`ifdef FETCH_STATS_EN
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("stat_fetch_rst", {16'h0, stat_fetch}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.stall = 1'b0; bus.redirect = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            @(posedge clk);
            #1;
            model_edge(1'b0, 1'b0, 16'h0);
        end
        check_eq("stat_fetch_sat", {16'h0, stat_fetch}, 32'h0000FFFF);
        check_eq("stat_fetch_model", {16'h0, stat_fetch}, 32'(m_fetch));
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) step(1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        check_eq("stat_stall", {16'h0, stat_stall}, 32'd3);
        check_eq("stat_stall_model", {16'h0, stat_stall}, 32'(m_stall));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
